// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared defaults, J/K action codes and load saturation helper
package jk_pkg;

    localparam int JK_W_DEFAULT   = 4;
    localparam int JK_MOD_DEFAULT = 10;

    // Encoding is {J, K} so an action can be unpacked straight onto a cell.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLR    = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_action_e;

    function automatic logic [31:0] sat_load(input logic [31:0] val, input logic [31:0] modulus);
        return (val >= modulus) ? (modulus - 32'd1) : val;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop bit cell with synchronous active-high clear
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic notQ
);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            Q <= (J & ~Q) | (~K & Q);
        end
    end

    assign notQ = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from JK cells
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = JK_W_DEFAULT,
    parameter int MODULUS = JK_MOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [31:0]      MOD32   = 32'(MODULUS);

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_target;
    logic             w_up_wrap;
    logic             w_dn_wrap;
    logic             w_wrap_step;
    logic             r_wrap;

    assign w_sat       = WIDTH'(sat_load(32'(load_val), MOD32));
    // >= rather than == so an out-of-range state recovers to 0 on the next up step.
    assign w_up_wrap   = (w_q >= MAX_CNT);
    assign w_dn_wrap   = (w_q == '0);
    assign w_wrap_step = en & (up ? w_up_wrap : w_dn_wrap);
    assign w_target    = up ? '0 : MAX_CNT;

    always_comb begin : steer
        jk_action_e act;
        logic       lo_ones;
        logic       lo_zeros;
        w_j      = '0;
        w_k      = '0;
        act      = JK_HOLD;
        lo_ones  = 1'b1;
        lo_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            act = JK_HOLD;
            if (load) begin
                act = w_sat[i] ? JK_SET : JK_CLR;
            end else if (w_wrap_step) begin
                act = w_target[i] ? JK_SET : JK_CLR;
            end else if (en && (up ? lo_ones : lo_zeros)) begin
                act = JK_TOGGLE;
            end
            {w_j[i], w_k[i]} = act;
            lo_ones  = lo_ones & w_q[i];
            lo_zeros = lo_zeros & w_qn[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .J    (w_j[g]),
            .K    (w_k[g]),
            .Q    (w_q[g]),
            .notQ (w_qn[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_step;
        end
    end

    assign count = w_q;
    assign wrap  = r_wrap;
    assign tc    = en & (up ? (w_q == MAX_CNT) : (w_q == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - randomized and directed checks of jk_mod_counter against an arithmetic model
module tb_jk_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       c_en;

    logic [3:0] count, count16, ca_count, cb_count;
    logic       tc, tc16, ca_tc, cb_tc;
    logic       wrap, wrap16, ca_wrap, cb_wrap;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt   = 0;
    int m16_cnt = 0;
    bit m_wrap   = 1'b0;
    bit m16_wrap = 1'b0;
    bit m_valid  = 1'b0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .wrap(wrap)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count16), .tc(tc16), .wrap(wrap16)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_ca (
        .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .count(ca_count), .tc(ca_tc), .wrap(ca_wrap)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_cb (
        .clk(clk), .rst(rst), .en(ca_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .count(cb_count), .tc(cb_tc), .wrap(cb_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_next(int c, int m, bit r, bit l, int lv, bit e, bit u);
        if (r) return 0;
        if (l) return (lv >= m) ? m - 1 : lv;
        if (!e) return c;
        if (u) return (c >= m - 1) ? 0 : c + 1;
        return (c == 0) ? m - 1 : c - 1;
    endfunction

    function automatic bit model_wrap(int c, int m, bit r, bit l, bit e, bit u);
        if (r || l || !e) return 1'b0;
        return u ? (c >= m - 1) : (c == 0);
    endfunction

    function automatic bit model_tc(int c, int m, bit e, bit u);
        return e && (u ? (c == m - 1) : (c == 0));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_cnt    <= model_next(m_cnt, 10, rst, load, int'(load_val), en, up);
        m_wrap   <= model_wrap(m_cnt, 10, rst, load, en, up);
        m16_cnt  <= model_next(m16_cnt, 16, rst, load, int'(load_val), en, up);
        m16_wrap <= model_wrap(m16_cnt, 16, rst, load, en, up);
        m_valid  <= m_valid | rst;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count", 32'(count), m_cnt);
            chk("wrap", 32'(wrap), int'(m_wrap));
            chk("tc", 32'(tc), int'(model_tc(m_cnt, 10, en, up)));
            chk("count16", 32'(count16), m16_cnt);
            chk("wrap16", 32'(wrap16), int'(m16_wrap));
            chk("tc16", 32'(tc16), int'(model_tc(m16_cnt, 16, en, up)));
        end
    end

    task automatic step(input bit r, input bit l, input int lv, input bit e, input bit u);
        rst      = r;
        load     = l;
        load_val = lv[3:0];
        en       = e;
        up       = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp2 [9] = '{6, 5, 4, 3, 2, 1, 0, 9, 8};
        bit ups [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        int exp4 [4] = '{6, 5, 6, 5};
        c_en = 1'b0;

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_wrap", 32'(wrap), 0);

        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 1, 1);
            chk("up_seq", 32'(count), (k + 1) % 10);
            chk("up_wrap", 32'(wrap), ((k + 1) % 10 == 0) ? 1 : 0);
            if (k == 8) chk("tc_at_9", 32'(tc), 1);
        end

        step(0, 1, 7, 0, 0);
        chk("load7", 32'(count), 7);
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 1, 0);
            chk("down_seq", 32'(count), exp2[k]);
            chk("down_wrap", 32'(wrap), (exp2[k] == 9) ? 1 : 0);
        end

        step(0, 1, 13, 0, 0);
        chk("load_sat", 32'(count), 9);
        step(0, 1, 3, 1, 1);
        chk("load_over_en", 32'(count), 3);
        chk("load_no_wrap", 32'(wrap), 0);

        step(0, 1, 5, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, k[0]);
            chk("hold", 32'(count), 5);
            chk("hold_tc", 32'(tc), 0);
            chk("hold_wrap", 32'(wrap), 0);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, ups[k]);
            chk("dir_toggle", 32'(count), exp4[k]);
        end

        step(0, 1, 7, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("pre_rst", 32'(count), 8);
        step(1, 0, 0, 1, 1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_wrap", 32'(wrap), 0);
        step(0, 0, 0, 1, 1);
        chk("resume1", 32'(count), 1);
        step(0, 0, 0, 1, 1);
        chk("resume2", 32'(count), 2);

        step(0, 1, 15, 0, 0);
        chk("m16_load15", 32'(count16), 15);
        step(0, 0, 0, 1, 1);
        chk("m16_wrap_cnt", 32'(count16), 0);
        chk("m16_wrap", 32'(wrap16), 1);

        step(1, 0, 0, 0, 1);
        c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step(0, 0, 0, 0, 1);
            chk("cascade", 32'(ca_count) + 32'(cb_count) * 32'd10, k % 100);
            if (k == 100) chk("cascade_wrap", 32'(cb_wrap), 1);
            if (k == 99) chk("cascade_tc", 32'(cb_tc), 1);
        end
        c_en = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
